// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the pipelined MIPS CPU
package cpu_pkg;
  localparam logic [31:0] TEXT_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] DATA_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0000;
  typedef enum logic {RUN, HALT} fetch_state_e;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: fetch stage control, ROM port and observation bundle
interface if_fetch_stage_if #(parameter int IM_AW = 10);
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      IF_PC;
  logic [31:0]      ID_PC;
  logic [31:0]      id_inst;
  logic             id_valid;
  logic             fetch_fault;
  logic [31:0]      fetch_cnt;
  modport master (
    input  stall, redirect_valid, redirect_pc, im_rdata,
    output im_addr, IF_PC, ID_PC, id_inst, id_valid, fetch_fault, fetch_cnt
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, im_rdata,
    input  im_addr, IF_PC, ID_PC, id_inst, id_valid, fetch_fault, fetch_cnt
  );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);
  logic [31:0] pc_q, inst_q;
  logic        valid_q;
  // bubble wins over load; neither means hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (load_i) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end
  end
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC ownership, ROM addressing and IF/ID loading with stall, redirect and fault halt
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE = TEXT_BASE_ADDR,
  parameter int          IM_DEPTH  = 1024,
  parameter int          IM_AW     = 10
) (
  input logic clk,
  input logic rst,
  if_fetch_stage_if.master bus
);
  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d, cnt_q, cnt_d, off, word;
  logic         fault_q, run, legal, mis, load, bubble, halt_d;
  // word index, legality and next-state selection in priority order
  always_comb begin
    off    = pc_q - TEXT_BASE;
    word   = {2'b00, off[31:2]};
    run    = state_q == RUN;
    legal  = pc_q[1:0] == 2'b00 && pc_q >= TEXT_BASE && word < 32'(IM_DEPTH);
    mis    = bus.redirect_pc[1:0] != 2'b00;
    halt_d = run && (bus.redirect_valid ? mis : !legal);
    bubble = !run || bus.redirect_valid || !legal;
    load   = run && !bus.redirect_valid && legal && !bus.stall;
    pc_d   = run && bus.redirect_valid && !mis ? bus.redirect_pc
           : load ? pc_q + 32'd4 : pc_q;
    cnt_d  = load ? cnt_q + 32'd1 : cnt_q;
  end
  // RUN/HALT state with PC, sticky fault and fetch counter; only rst leaves HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= TEXT_BASE;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= halt_d ? HALT : state_q;
      fault_q <= fault_q || halt_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end
  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .bubble_i (bubble),
    .pc_i     (pc_q),
    .inst_i   (bus.im_rdata),
    .pc_o     (bus.ID_PC),
    .inst_o   (bus.id_inst),
    .valid_o  (bus.id_valid)
  );
  assign bus.im_addr     = word[IM_AW-1:0];
  assign bus.IF_PC       = pc_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fetch_cnt   = cnt_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch, stall, redirect, fault halt and async reset
module tb_if_fetch_stage;
  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
  int checks = 0, errors = 0;
  if_fetch_stage_if #(.IM_AW(10)) bus ();
  if_fetch_stage_if #(.IM_AW(2))  bus2 ();
  if_fetch_stage #(.IM_DEPTH(1024), .IM_AW(10)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  if_fetch_stage #(.IM_DEPTH(4),    .IM_AW(2))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));
  always #5 clk = ~clk;
  assign bus.im_rdata  = 32'h2008_0001 + {22'b0, bus.im_addr};
  assign bus2.im_rdata = 32'h2008_0001 + {30'b0, bus2.im_addr};
  initial begin
    bus2.stall = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string name, input logic [31:0] if_pc, id_pc, inst,
                              input logic valid, fault, input logic [31:0] cnt);
    checks++;
    if (bus.IF_PC !== if_pc || bus.ID_PC !== id_pc || bus.id_inst !== inst ||
        bus.id_valid !== valid || bus.fetch_fault !== fault || bus.fetch_cnt !== cnt) begin
      errors++;
      $display("FAIL %s: got IF_PC=%h ID_PC=%h inst=%h v=%b f=%b cnt=%0d want IF_PC=%h ID_PC=%h inst=%h v=%b f=%b cnt=%0d",
               name, bus.IF_PC, bus.ID_PC, bus.id_inst, bus.id_valid, bus.fetch_fault, bus.fetch_cnt,
               if_pc, id_pc, inst, valid, fault, cnt);
    end
  endtask

  task automatic test_reset();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    #12;
    expect_state("reset", 32'h3000, 0, 0, 0, 0, 0);
    checks++;
    if (bus.im_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_im_addr: got %h want 0", bus.im_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    tick();
    expect_state("run1", 32'h3004, 32'h3000, 32'h2008_0001, 1, 0, 1);
    tick();
    expect_state("run2", 32'h3008, 32'h3004, 32'h2008_0002, 1, 0, 2);
    checks++;
    if (bus.im_addr !== 10'd2) begin
      errors++;
      $display("FAIL run_im_addr: got %h want 2", bus.im_addr);
    end
    tick();
    expect_state("run3", 32'h300C, 32'h3008, 32'h2008_0003, 1, 0, 3);
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    tick();
    expect_state("stall1", 32'h300C, 32'h3008, 32'h2008_0003, 1, 0, 3);
    tick();
    expect_state("stall2", 32'h300C, 32'h3008, 32'h2008_0003, 1, 0, 3);
    bus.stall = 1'b0;
    tick();
    expect_state("stall_release", 32'h3010, 32'h300C, 32'h2008_0004, 1, 0, 4);
  endtask

  task automatic test_redirect();
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3040;
    tick();
    expect_state("redir_bubble", 32'h3040, 0, 0, 0, 0, 4);
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    expect_state("redir_target", 32'h3044, 32'h3040, 32'h2008_0011, 1, 0, 5);
  endtask

  task automatic test_back_to_back();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3100;
    tick();
    expect_state("b2b_first", 32'h3100, 0, 0, 0, 0, 5);
    bus.redirect_pc = 32'h3000;
    tick();
    expect_state("b2b_second", 32'h3000, 0, 0, 0, 0, 5);
    bus.redirect_valid = 1'b0;
    tick();
    expect_state("b2b_target", 32'h3004, 32'h3000, 32'h2008_0001, 1, 0, 6);
  endtask

  task automatic test_misaligned();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h3042;
    tick();
    expect_state("mis_halt", 32'h3004, 0, 0, 0, 1, 6);
    bus.redirect_pc = 32'h3000;
    for (int i = 0; i < 10; i++) begin
      bus.stall = i[0];
      bus.redirect_valid = ~i[1];
      tick();
      expect_state($sformatf("halt_hold%0d", i), 32'h3004, 0, 0, 0, 1, 6);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_state("async_reset", 32'h3000, 0, 0, 0, 0, 0);
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    expect_state("restart", 32'h3004, 32'h3000, 32'h2008_0001, 1, 0, 1);
  endtask

  task automatic test_im_depth();
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus2.IF_PC !== 32'h3010 || bus2.ID_PC !== 32'h300C || bus2.id_inst !== 32'h2008_0004 ||
        bus2.id_valid !== 1'b1 || bus2.fetch_fault !== 1'b0 || bus2.fetch_cnt !== 32'd4) begin
      errors++;
      $display("FAIL depth_last: got IF_PC=%h ID_PC=%h inst=%h v=%b f=%b cnt=%0d want 3010 300c 20080004 1 0 4",
               bus2.IF_PC, bus2.ID_PC, bus2.id_inst, bus2.id_valid, bus2.fetch_fault, bus2.fetch_cnt);
    end
    tick();
    checks++;
    if (bus2.IF_PC !== 32'h3010 || bus2.id_valid !== 1'b0 || bus2.id_inst !== 32'h0 ||
        bus2.fetch_fault !== 1'b1 || bus2.fetch_cnt !== 32'd4) begin
      errors++;
      $display("FAIL depth_halt: got IF_PC=%h v=%b inst=%h f=%b cnt=%0d want 3010 0 0 1 4",
               bus2.IF_PC, bus2.id_valid, bus2.id_inst, bus2.fetch_fault, bus2.fetch_cnt);
    end
    tick();
    checks++;
    if (bus2.IF_PC !== 32'h3010 || bus2.fetch_fault !== 1'b1 || bus2.fetch_cnt !== 32'd4) begin
      errors++;
      $display("FAIL depth_hold: got IF_PC=%h f=%b cnt=%0d want 3010 1 4",
               bus2.IF_PC, bus2.fetch_fault, bus2.fetch_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_misaligned();
    test_async_reset();
    test_im_depth();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
